mips_bus_mem_slave: RTL and testbench

Wait-state memory slave sitting directly downstream of `mips_cpu_bus` on its Avalon-style memory bus. It answers the CPU's `read`/`write` requests with a programmable number of `waitrequest` stall cycles and applies byte-enabled writes. It maps two windows, a boot window at the reset vector and a data window at address 0, onto one word array, and flags protocol and decode errors. It replaces the zero-latency RAM in CPU benches so that stall handling in the CPU is exercised.

---
 rtl/mips_bus_pkg.sv | 27 ++
 rtl/mips_bus_mem_decode.sv | 45 ++++
 rtl/mips_bus_mem_slave.sv | 146 ++++++++++++++
 tb/tb_mips_bus_mem_slave.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and helpers for the wait-state memory slave.
//   bus_state_t       - slave FSM states (IDLE, WAIT, ACK)
//   BOOT_BASE_DEFAULT - default byte base of the boot (reset vector) window
//   DATA_BASE         - byte base of the data window
//   byte_mask()       - expands a 4-bit byteenable into a 32-bit write mask
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  localparam logic [31:0] BOOT_BASE_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] DATA_BASE         = 32'h0000_0000;

  // Byte k of the mask is all ones when byteenable[k] is set.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mips_bus_mem_decode.sv
// mips_bus_mem_decode: combinational address decode for the memory slave.
// Maps a byte address onto the shared word array:
//   data window [DATA_BASE, DATA_BASE+MEM_WORDS*2)   -> lower half of the array
//   boot window [BOOT_BASE, BOOT_BASE+MEM_WORDS*2)   -> upper half of the array
// Ports:
//   address    in  32      byte address
//   hit        out 1       address falls in one of the windows
//   index      out IDX_W   word index into the array (aligned word)
//   misaligned out 1       address[1:0] != 0
module mips_bus_mem_decode
  import mips_bus_pkg::*;
#(
  parameter int unsigned  MEM_WORDS = 2048,
  parameter logic [31:0]  BOOT_BASE = BOOT_BASE_DEFAULT,
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [31:0]      address,
  output logic             hit,
  output logic [IDX_W-1:0] index,
  output logic             misaligned
);

  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 2);
  localparam logic [31:0] HALF      = 32'(MEM_WORDS / 2);

  logic [31:0] data_off;
  logic [31:0] boot_off;

  // Offsets wrap modulo 2^32, so a single unsigned compare bounds each window.
  always_comb begin
    data_off   = address - DATA_BASE;
    boot_off   = address - BOOT_BASE;
    hit        = 1'b0;
    index      = '0;
    misaligned = |address[1:0];
    if (data_off < WIN_BYTES) begin
      hit   = 1'b1;
      index = IDX_W'(data_off >> 2);
    end else if (boot_off < WIN_BYTES) begin
      hit   = 1'b1;
      index = IDX_W'(HALF + (boot_off >> 2));
    end
  end

endmodule

// File: rtl/mips_bus_mem_slave.sv
// mips_bus_mem_slave: Avalon-style wait-state memory slave for mips_cpu_bus.
// Each access takes WAIT_CYCLES+2 cycles (accept, WAIT_CYCLES stalls, ACK);
// writes are byte-enabled and land at the edge ending ACK.
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   synchronous active-low reset
//   address      in  32  byte address (word-aligned expected)
//   write, read  in  1   request strobes, held while waitrequest is high
//   waitrequest  out 1   stall, combinational: (read|write) && state!=ACK
//   writedata    in  32  write data
//   byteenable   in  4   per-byte write enable
//   readdata     out 32  read data, valid in the ACK cycle
//   bus_error    out 1   sticky decode/protocol error flag
module mips_bus_mem_slave
  import mips_bus_pkg::*;
#(
  parameter string       RAM_INIT_FILE = "",
  parameter int unsigned MEM_WORDS     = 2048,
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter logic [31:0] BOOT_BASE     = BOOT_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  bus_state_t       state;
  logic [3:0]       cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_be;
  logic             lat_rd;
  logic             lat_wr;
  logic [31:0]      mem [MEM_WORDS];

  logic             req;
  logic [31:0]      dec_addr;
  logic             cur_rd;
  logic             cur_wr;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_index;
  logic             dec_misaligned;
  logic             no_data;
  logic             mem_we;
  logic [31:0]      wmask;

  // Decode the live bus while accepting, the latched request afterwards.
  always_comb begin
    dec_addr = (state == IDLE) ? address : lat_addr;
    cur_rd   = (state == IDLE) ? read    : lat_rd;
    cur_wr   = (state == IDLE) ? write   : lat_wr;
  end

  mips_bus_mem_decode #(
    .MEM_WORDS (MEM_WORDS),
    .BOOT_BASE (BOOT_BASE)
  ) u_decode (
    .address    (dec_addr),
    .hit        (dec_hit),
    .index      (dec_index),
    .misaligned (dec_misaligned)
  );

  assign req         = read | write;
  assign waitrequest = req && (state != ACK);
  // Misses and read+write collisions return zero data.
  assign no_data     = !dec_hit || (cur_rd && cur_wr);
  // Reset in ACK suppresses the write.
  assign mem_we      = reset && (state == ACK) && lat_wr && !lat_rd && dec_hit;
  assign wmask       = byte_mask(lat_be);

  // Word array: not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[dec_index] <= (mem[dec_index] & ~wmask) | (lat_wdata & wmask);
    end
  end

  // Access FSM with latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      readdata  <= '0;
      bus_error <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_rd    <= read;
            lat_wr    <= write;
            if (dec_misaligned || !dec_hit || (read && write)) begin
              bus_error <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state    <= ACK;
              cnt      <= '0;
              readdata <= no_data ? 32'h0 : mem[dec_index];
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Master abandoned the access: no write, flag it.
            state     <= IDLE;
            cnt       <= '0;
            bus_error <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) begin
              state    <= ACK;
              readdata <= no_data ? 32'h0 : mem[dec_index];
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_slave.sv
// tb_mips_bus_mem_slave: self-checking bench for mips_bus_mem_slave.
// Two instances: dut_a with 2 wait cycles, dut_b with none. A word-array
// model applies the window/byte-lane/error rules to predict read data,
// stall counts and the sticky error flag.
module tb_mips_bus_mem_slave;

  localparam int unsigned MW   = 256;
  localparam logic [31:0] BOOT = 32'hBFC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_wr, a_rd, a_wreq, a_err, b_wr, b_rd, b_wreq, b_err;
  logic [3:0]  a_be, b_be;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  logic [31:0] model_a [MW];
  logic [31:0] model_b [MW];
  bit          err_a = 1'b0;
  bit          err_b = 1'b0;

  mips_bus_mem_slave #(
    .RAM_INIT_FILE (""), .MEM_WORDS (MW), .WAIT_CYCLES (2), .BOOT_BASE (BOOT)
  ) dut_a (
    .clk (clk), .reset (reset), .address (a_addr), .write (a_wr), .read (a_rd),
    .waitrequest (a_wreq), .writedata (a_wdata), .byteenable (a_be),
    .readdata (a_rdata), .bus_error (a_err)
  );

  mips_bus_mem_slave #(
    .RAM_INIT_FILE (""), .MEM_WORDS (MW), .WAIT_CYCLES (0), .BOOT_BASE (BOOT)
  ) dut_b (
    .clk (clk), .reset (reset), .address (b_addr), .write (b_wr), .read (b_rd),
    .waitrequest (b_wreq), .writedata (b_wdata), .byteenable (b_be),
    .readdata (b_rdata), .bus_error (b_err)
  );

  // Word index for a byte address, -1 on a miss.
  function automatic int midx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BOOT;
    if (a < 32'(MW * 2)) return int'(a / 4);
    if (off < 32'(MW * 2)) return int'(MW / 2) + int'(off / 4);
    return -1;
  endfunction

  // Applies one completed access to the model; returns expected readdata.
  function automatic logic [31:0] model_apply(input bit sel, input logic r, input logic w,
                                              input logic [31:0] a, input logic [31:0] d,
                                              input logic [3:0] be);
    int idx;
    logic [31:0] word, res;
    idx = midx(a);
    if (idx < 0 || a[1:0] != 2'b00 || (r && w)) begin
      if (sel) err_b = 1'b1; else err_a = 1'b1;
    end
    word = (idx < 0) ? 32'h0 : (sel ? model_b[idx] : model_a[idx]);
    res  = (idx < 0 || (r && w)) ? 32'h0 : word;
    if (w && !r && idx >= 0) begin
      for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = d[8*k +: 8];
      if (sel) model_b[idx] = word; else model_a[idx] = word;
    end
    return res;
  endfunction

  // Drive one request from just after a rising edge; returns the ACK-cycle
  // readdata and how many sampled cycles had waitrequest high. Ends just
  // after the edge closing ACK with the request deasserted.
  task automatic access(input bit sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int wcnt);
    bit done;
    if (sel) begin b_rd = r; b_wr = w; b_addr = a; b_wdata = d; b_be = be; end
    else     begin a_rd = r; a_wr = w; a_addr = a; a_wdata = d; a_be = be; end
    wcnt = 0;
    done = 1'b0;
    rd   = 32'h0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (sel ? b_wreq : a_wreq) wcnt++;
      else begin
        done = 1'b1;
        rd   = sel ? b_rdata : a_rdata;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: addr %h still stalled after 32 cycles, required ACK", a);
    end
    @(posedge clk); #1;
    if (sel) begin b_rd = 1'b0; b_wr = 1'b0; end
    else     begin a_rd = 1'b0; a_wr = 1'b0; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_rd = 1'b1; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_be = 4'h0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_wreq !== 1'b1) begin errors++; $display("FAIL reset_held_wreq: got %b required 1", a_wreq); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", a_rdata); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b required 0", a_err); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL reset_err_b: got %b required 0", b_err); end
    a_rd = 1'b0;
    #1;
    checks++; if (a_wreq !== 1'b0) begin errors++; $display("FAIL idle_wreq: got %b required 0", a_wreq); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_boot_read();
    logic [31:0] rd, exp;
    int wc;
    exp = model_apply(1'b0, 1'b0, 1'b1, BOOT, 32'h8C03_0001, 4'hF);
    access(1'b0, 1'b0, 1'b1, BOOT, 32'h8C03_0001, 4'hF, rd, wc);
    checks++; if (wc != 3) begin errors++; $display("FAIL boot_write_stall: got %0d required 3", wc); end
    exp = model_apply(1'b0, 1'b1, 1'b0, BOOT, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, BOOT, 32'h0, 4'h0, rd, wc);
    checks++; if (wc != 3) begin errors++; $display("FAIL boot_read_stall: got %0d required 3", wc); end
    checks++; if (rd !== 32'h8C03_0001 || rd !== exp) begin errors++; $display("FAIL boot_read_data: got %h required 8c030001", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, exp;
    int wc;
    exp = model_apply(1'b0, 1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'hF);
    access(1'b0, 1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'hF, rd, wc);
    exp = model_apply(1'b0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0101);
    access(1'b0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0101, rd, wc);
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd, wc);
    checks++; if (rd !== 32'h11AD_33EF || rd !== exp) begin errors++; $display("FAIL byte_enable: got %h required 11ad33ef", rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL byte_enable_err: got %b required 0", a_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1, e0, e1;
    int wc0, wc1, c0;
    e0 = model_apply(1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF);
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, rd0, wc0);
    e0 = model_apply(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5_0002, 4'hF);
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5_0002, 4'hF, rd0, wc0);
    c0 = cycle;
    e0 = model_apply(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd0, wc0);
    e1 = model_apply(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd1, wc1);
    checks++; if (wc0 != 1 || wc1 != 1) begin errors++; $display("FAIL b2b_stall: got %0d/%0d required 1/1", wc0, wc1); end
    checks++; if (cycle - c0 != 4) begin errors++; $display("FAIL b2b_cycles: got %0d required 4", cycle - c0); end
    checks++; if (rd0 !== e0) begin errors++; $display("FAIL b2b_data0: got %h required %h", rd0, e0); end
    checks++; if (rd1 !== e1) begin errors++; $display("FAIL b2b_data1: got %h required %h", rd1, e1); end
  endtask

  task automatic test_collision_and_reset();
    logic [31:0] rd, exp;
    int wc;
    exp = model_apply(1'b0, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF);
    access(1'b0, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, rd, wc);
    exp = model_apply(1'b0, 1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF);
    access(1'b0, 1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, rd, wc);
    checks++; if (rd !== exp) begin errors++; $display("FAIL collision_data: got %h required %h", rd, exp); end
    checks++; if (wc != 3) begin errors++; $display("FAIL collision_stall: got %0d required 3", wc); end
    checks++; if (a_err !== err_a) begin errors++; $display("FAIL collision_err: got %b required %b", a_err, err_a); end
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, wc);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL collision_unchanged: got %h required 0badf00d", rd); end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    err_a = 1'b0;
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_clears_err: got %b required 0", a_err); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_clears_rdata: got %h required 0", a_rdata); end
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, wc);
    checks++; if (wc != 3 || rd !== exp) begin errors++; $display("FAIL post_reset_read: got %0d/%h required 3/%h", wc, rd, exp); end
  endtask

  task automatic test_miss();
    logic [31:0] rd, exp;
    int wc;
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0, rd, wc);
    checks++; if (rd !== 32'h0 || rd !== exp) begin errors++; $display("FAIL miss_data: got %h required 0", rd); end
    checks++; if (wc != 3) begin errors++; $display("FAIL miss_stall: got %0d required 3", wc); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL miss_err: got %b required 1", a_err); end
  endtask

  task automatic test_drop();
    logic [31:0] rd, exp;
    int wc;
    exp = model_apply(1'b0, 1'b0, 1'b1, 32'hC, 32'hCAFE_0000, 4'hF);
    access(1'b0, 1'b0, 1'b1, 32'hC, 32'hCAFE_0000, 4'hF, rd, wc);
    a_wr = 1'b1; a_addr = 32'hC; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
    @(posedge clk); #1;
    checks++; if (a_wreq !== 1'b1) begin errors++; $display("FAIL drop_stalled: got %b required 1", a_wreq); end
    a_wr = 1'b0;
    @(posedge clk); #1;
    err_a = 1'b1;
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b required 1", a_err); end
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, rd, wc);
    checks++; if (wc != 3 || rd !== 32'hCAFE_0000) begin errors++; $display("FAIL drop_unchanged: got %0d/%h required 3/cafe0000", wc, rd); end
    // Reset while a write is stalled must abort it.
    exp = model_apply(1'b0, 1'b0, 1'b1, 32'h10, 32'h0102_0304, 4'hF);
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0102_0304, 4'hF, rd, wc);
    a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; a_wr = 1'b0;
    err_a = 1'b0;
    exp = model_apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, wc);
    checks++; if (wc != 3 || rd !== 32'h0102_0304) begin errors++; $display("FAIL reset_abort: got %0d/%h required 3/01020304", wc, rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_abort_err: got %b required 0", a_err); end
  endtask

  task automatic test_random(input bit sel, input int n);
    logic [31:0] a, d, exp, rd;
    logic [3:0]  be;
    logic        r, w;
    int          wc, kind, word, exp_wc;
    exp_wc = sel ? 1 : 3;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 2; j++) begin
        a = (j == 1 ? BOOT : 32'h0) + 32'(i * 4);
        d = $urandom;
        exp = model_apply(sel, 1'b0, 1'b1, a, d, 4'hF);
        access(sel, 1'b0, 1'b1, a, d, 4'hF, rd, wc);
      end
    end
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 9));
      d    = $urandom;
      be   = 4'($urandom);
      word = int'($urandom_range(0, 15));
      a    = ($urandom_range(0, 1) == 1 ? BOOT : 32'h0) + 32'(word * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (kind == 0) begin
        a = 32'h1000_0000 + 32'(word * 4);
        w = 1'($urandom_range(0, 1));
        r = !w;
      end else if (kind == 1) begin
        r = 1'b1; w = 1'b1;
      end else if (kind <= 5) begin
        r = 1'b1; w = 1'b0;
      end else begin
        r = 1'b0; w = 1'b1;
      end
      exp = model_apply(sel, r, w, a, d, be);
      access(sel, r, w, a, d, be, rd, wc);
      checks++; if (wc != exp_wc) begin errors++; $display("FAIL rand_stall[%0d]: addr %h got %0d required %0d", i, a, wc, exp_wc); end
      if (r) begin
        checks++; if (rd !== exp) begin errors++; $display("FAIL rand_data[%0d]: addr %h got %h required %h", i, a, rd, exp); end
      end
      checks++;
      if ((sel ? b_err : a_err) !== (sel ? err_b : err_a)) begin
        errors++;
        $display("FAIL rand_err[%0d]: addr %h got %b required %b", i, a, sel ? b_err : a_err, sel ? err_b : err_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_read();
    test_byte_enable();
    test_back_to_back();
    test_collision_and_reset();
    test_miss();
    test_drop();
    test_random(1'b0, 80);
    test_random(1'b1, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
